led_pattern_animator: RTL

Parametrised successor to the static LED-matrix pattern block. It holds a double-buffered red/green frame of ROWS x COLS pixels and drives the LED driver's RedPixels/GrnPixels arrays. It animates the displayed frame in one of four modes (static, blink, scroll-left, scroll-up), stepped by an internal tick prescaler. The block sits between game/control logic, which writes rows and requests swaps, and the LED matrix driver.

---
 rtl/led_pattern_animator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_animator.sv
// rtl/led_pattern_animator.sv - double-buffered ROWSxCOLS red/green frame animator (static, blink, scroll-left, scroll-up)
// Define LED_ANIM_WRAP_EN for rotating scroll; otherwise scrolling shifts in zeros.
module led_pattern_animator #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 12500000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [COLS-1:0]           wr_red,
  input  logic [COLS-1:0]           wr_grn,
  input  logic                      swap_req,
  output logic                      swap_pending,
  output logic                      frame_tick,
  output logic [ROWS-1:0][COLS-1:0] RedPixels,
  output logic [ROWS-1:0][COLS-1:0] GrnPixels
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
  localparam int OW   = $clog2(MAXD);
  localparam int CNTW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    M_STATIC = 2'b00,
    M_BLINK  = 2'b01,
    M_LEFT   = 2'b10,
    M_UP     = 2'b11
  } mode_e;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  frame_t          back_red_q, back_red_d, back_grn_q, back_grn_d;
  frame_t          front_red_q, front_red_d, front_grn_q, front_grn_d;
  frame_t          red_out_q, red_out_d, grn_out_q, grn_out_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic            visible_q, visible_d;
  logic            pending_q, pending_d;
  logic            frame_tick_q, frame_tick_d;
  logic [1:0]      mode_q, mode_d;

  logic tick, commit, mode_chg;
  int   off, sr, sc;
  logic ok;

  always_comb begin
    tick     = en && (cnt_q == CNTW'(TICK_DIV - 1));
    commit   = pending_q && (tick || !en);
    mode_chg = (mode != mode_q);

    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CNTW'(1);

    back_red_d = back_red_q;
    back_grn_d = back_grn_q;
    if (wr_en && (32'(wr_row) < ROWS)) begin
      back_red_d[wr_row] = wr_red;
      back_grn_d[wr_row] = wr_grn;
    end

    // The copy takes the pre-edge back buffer, so a same-cycle write stays behind.
    front_red_d = commit ? back_red_q : front_red_q;
    front_grn_d = commit ? back_grn_q : front_grn_q;
    pending_d   = commit ? swap_req : (pending_q | swap_req);

    offset_d  = offset_q;
    visible_d = visible_q;
    if (commit || mode_chg) begin
      offset_d  = '0;
      visible_d = 1'b1;
    end else if (tick) begin
      unique case (mode_e'(mode))
        M_BLINK: visible_d = !visible_q;
        M_LEFT:  offset_d = (offset_q == OW'(COLS - 1)) ? '0 : offset_q + OW'(1);
        M_UP:    offset_d = (offset_q == OW'(ROWS - 1)) ? '0 : offset_q + OW'(1);
        default: ;
      endcase
    end

    frame_tick_d = tick;
    mode_d       = mode;
  end

  always_comb begin
    red_out_d = '0;
    grn_out_d = '0;
    off       = int'(offset_q);
    sr        = 0;
    sc        = 0;
    ok        = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        sr = r;
        sc = c;
        ok = 1'b1;
        unique case (mode_e'(mode))
          M_BLINK: ok = visible_q;
`ifdef LED_ANIM_WRAP_EN
          M_LEFT:  sc = ((c - off) % COLS + COLS) % COLS;
          M_UP:    sr = (r + off) % ROWS;
`else
          M_LEFT:  sc = c - off;
          M_UP:    sr = r + off;
`endif
          default: ;
        endcase
        // Out-of-range sources are the zero fill of a non-wrapping shift.
        if (ok && sr >= 0 && sr < ROWS && sc >= 0 && sc < COLS) begin
          red_out_d[r][c] = front_red_q[sr[RW-1:0]][sc[CW-1:0]];
          grn_out_d[r][c] = front_grn_q[sr[RW-1:0]][sc[CW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      back_red_q   <= '0;
      back_grn_q   <= '0;
      front_red_q  <= '0;
      front_grn_q  <= '0;
      red_out_q    <= '0;
      grn_out_q    <= '0;
      cnt_q        <= '0;
      offset_q     <= '0;
      visible_q    <= 1'b1;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      mode_q       <= 2'b00;
    end else begin
      back_red_q   <= back_red_d;
      back_grn_q   <= back_grn_d;
      front_red_q  <= front_red_d;
      front_grn_q  <= front_grn_d;
      red_out_q    <= red_out_d;
      grn_out_q    <= grn_out_d;
      cnt_q        <= cnt_d;
      offset_q     <= offset_d;
      visible_q    <= visible_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
    end
  end

  assign swap_pending = pending_q;
  assign frame_tick   = frame_tick_q;
  assign RedPixels    = red_out_q;
  assign GrnPixels    = grn_out_q;

endmodule
